alu_issue_unit: RTL and testbench
=================================

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 Parameter DATA_W, default 64, sets the operand, result and register width.
REQ-002 Parameter REG_N, default 32, sets the register count; register REG_N-1 is the hardwired zero register.
REQ-003 clock  input  1  is the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  is an asynchronous, active-high reset.
REQ-005 issue_valid  input  1  means an operation request is present.
REQ-006 issue_ready  output  1  means the unit can accept a request this cycle.
REQ-007 issue_rd, issue_rn, issue_rm  input  5 each  are the destination, operand-A and operand-B register indices.
REQ-008 issue_fs  input  5  is the ALU function select.
REQ-009 issue_c  input  1  is the ALU carry-in.
REQ-010 issue_use_imm  input  1  selects issue_imm instead of R[rm] for operand B.
REQ-011 issue_imm  input  DATA_W  is the immediate operand.
REQ-012 issue_set_flags  input  1  enables the status-register update.
REQ-013 alu_a, alu_b  output  DATA_W  drive the ALU operands.
REQ-014 alu_fs  output  5  and alu_c  output  1  drive the ALU function select and carry-in.
REQ-015 alu_f  input  DATA_W  is the combinational ALU result.
REQ-016 alu_status  input  4  carries the ALU flags {V,C,N,Z}.
REQ-017 done  output  1  is a one-cycle completion pulse.
REQ-018 result  output  DATA_W  is the captured result, valid while done is high.
REQ-019 status  output  4  is the architectural flag register {V,C,N,Z}.
REQ-020 dbg_addr  input  5  and dbg_data  output  DATA_W  form a combinational register-file read port.

Function
REQ-021 The FSM SHALL have states IDLE, READ, EXEC and WB, and SHALL advance IDLE->READ->EXEC->WB->IDLE.
REQ-022 issue_ready SHALL be 1 only in IDLE; a request is accepted on an edge with issue_valid=1 and issue_ready=1, and all issue_* fields are latched at that edge.
REQ-023 In READ, the unit SHALL latch opA=R[rn] and opB=(use_imm ? imm : R[rm]).
REQ-024 alu_a, alu_b, alu_fs and alu_c SHALL be registered, SHALL hold the latched values throughout EXEC, and SHALL be 0 otherwise.
REQ-025 The unit SHALL capture alu_f and alu_status at the edge ending EXEC.
REQ-026 In WB, the unit SHALL write R[rd]=captured result unless rd=REG_N-1.
REQ-027 In WB, the unit SHALL load status from the captured flags only if set_flags is set; otherwise status holds its value.
REQ-028 done SHALL be 1 exactly during WB, and result SHALL be driven only during WB and be 0 otherwise.
REQ-029 Latency: for an acceptance edge at cycle T, done SHALL be high in cycle T+3, and issue_ready SHALL be high again in cycle T+4.
REQ-030 Reads of index REG_N-1 on any port SHALL return 0; writes to that index SHALL be discarded.
REQ-031 An operation that reads the destination of the previous operation SHALL see the written value, because WB completes before the next READ.
REQ-032 Requests presented while not in IDLE SHALL be ignored and SHALL not be queued.
REQ-033 Indices SHALL be used modulo 32 with no range error; the carry and overflow flags come solely from the ALU.

Reset
REQ-034 While reset is high, the FSM SHALL be in IDLE, all registers, status, alu_*, result and done SHALL be 0, and issue_ready SHALL be 1.
REQ-035 A reset during READ, EXEC or WB SHALL abort the operation with no register or status write, including a WB cycle cut short by reset.

Structure
REQ-036 A shared package SHALL hold the FSM state enumeration, the DATA_W and REG_N defaults, and the status bit positions (V=3, C=2, N=1, Z=0).
REQ-037 The register file SHALL be one sub-module, regfile_2r1w, with two read ports, one write port and the zero-register rule; the debug port reuses a third read mux within it.

Verification
REQ-038 Bench drives the ALU ports with a stub computing f=a+b+c and a matching {V,C,N,Z}.
REQ-039 Scenario: after reset, dbg_data for every index = 0, status = 0, issue_ready = 1.
REQ-040 Scenario: issue rd=1, use_imm, imm=205 -> done at T+3 with result=205; then rd=2, imm=512 -> dbg R2=512.
REQ-041 Scenario: rd=3, rn=1, rm=2, set_flags -> result=717 and status=0000; rd=4, rn=3, imm=all-ones, c=1, set_flags -> result=717, C=1.
REQ-042 Scenario: rd=31 with imm=5 -> done pulses, R31 still reads 0, status unchanged with set_flags=0.
REQ-043 Scenario: issue_valid held high for 6 cycles -> exactly two acceptances, 4 cycles apart.
REQ-044 Scenario: reset asserted during EXEC of rd=5, imm=9 -> R5 = 0, no done pulse, issue_ready = 1 after release.

Source files
------------

// File: rtl/alu_issue_unit_pkg.sv
// Shared types and constants for the ALU issue unit.
package alu_issue_unit_pkg;

    // Issue FSM: one operation walks IDLE -> READ -> EXEC -> WB -> IDLE.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StExec = 2'd2,
        StWb   = 2'd3
    } state_e;

    localparam int unsigned DataWDefault = 64;
    localparam int unsigned RegNDefault  = 32;

    // Bit positions inside the {V,C,N,Z} flag vector.
    localparam int unsigned StatusV = 3;
    localparam int unsigned StatusC = 2;
    localparam int unsigned StatusN = 1;
    localparam int unsigned StatusZ = 0;

endpackage

// File: rtl/alu_issue_unit_regfile_2r1w.sv
// Register file: two operand read ports, one debug read port, one write port.
// The top index (REG_N-1) is the zero register: it reads as 0 and ignores writes.
module regfile_2r1w
    import alu_issue_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned REG_N  = RegNDefault
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [4:0]        rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic [4:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    input  logic              we_i,
    input  logic [4:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] mem_q [REG_N];

    // Indices at or above the zero register read as 0.
    assign ra_data_o  = (32'(ra_addr_i)  >= REG_N - 1) ? '0 : mem_q[ra_addr_i];
    assign rb_data_o  = (32'(rb_addr_i)  >= REG_N - 1) ? '0 : mem_q[rb_addr_i];
    assign dbg_data_o = (32'(dbg_addr_i) >= REG_N - 1) ? '0 : mem_q[dbg_addr_i];

    // Storage: cleared on reset, writes to the zero register are dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (32'(waddr_i) < REG_N - 1)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue unit: accepts one request at a time, reads operands, drives an
// external combinational ALU for one cycle, then writes back result and flags.
module alu_issue_unit
    import alu_issue_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned REG_N  = RegNDefault
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [4:0]        issue_rd,
    input  logic [4:0]        issue_rn,
    input  logic [4:0]        issue_rm,
    input  logic [4:0]        issue_fs,
    input  logic              issue_c,
    input  logic              issue_use_imm,
    input  logic [DATA_W-1:0] issue_imm,
    input  logic              issue_set_flags,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_fs,
    output logic              alu_c,
    input  logic [DATA_W-1:0] alu_f,
    input  logic [3:0]        alu_status,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        status,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e state_q, state_d;

    logic [4:0]        rd_q, rn_q, rm_q, fs_q;
    logic              c_q, use_imm_q, set_flags_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [4:0]        alu_fs_q, alu_fs_d;
    logic              alu_c_q, alu_c_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [3:0]        flags_q, flags_d;
    logic [3:0]        status_q, status_d;
    logic [DATA_W-1:0] rn_data, rm_data;
    logic              accept;
    logic              wb_en;

    assign accept = issue_valid && (state_q == StIdle);
    assign wb_en  = (state_q == StWb);

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regfile (
        .clk_i      (clock),
        .rst_i      (reset),
        .ra_addr_i  (rn_q),
        .ra_data_o  (rn_data),
        .rb_addr_i  (rm_q),
        .rb_data_o  (rm_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .we_i       (wb_en),
        .waddr_i    (rd_q),
        .wdata_i    (res_q)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fixed four-cycle walk once a request is accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (issue_valid) state_d = StRead;
            StRead: state_d = StExec;
            StExec: state_d = StWb;
            StWb:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        issue_ready = (state_q == StIdle);
        done        = (state_q == StWb);
        result      = (state_q == StWb) ? res_q : '0;
    end

    // Datapath next state: operands only live in EXEC, result captured at end of EXEC.
    always_comb begin
        alu_a_d  = '0;
        alu_b_d  = '0;
        alu_fs_d = '0;
        alu_c_d  = 1'b0;
        res_d    = res_q;
        flags_d  = flags_q;
        status_d = status_q;
        if (state_q == StRead) begin
            alu_a_d  = rn_data;
            alu_b_d  = use_imm_q ? imm_q : rm_data;
            alu_fs_d = fs_q;
            alu_c_d  = c_q;
        end
        if (state_q == StExec) begin
            res_d   = alu_f;
            flags_d = alu_status;
        end
        if (wb_en && set_flags_q) begin
            status_d[StatusV] = flags_q[StatusV];
            status_d[StatusC] = flags_q[StatusC];
            status_d[StatusN] = flags_q[StatusN];
            status_d[StatusZ] = flags_q[StatusZ];
        end
    end

    // Datapath registers, including the request fields latched on acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q        <= '0;
            rn_q        <= '0;
            rm_q        <= '0;
            fs_q        <= '0;
            c_q         <= 1'b0;
            use_imm_q   <= 1'b0;
            imm_q       <= '0;
            set_flags_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fs_q    <= '0;
            alu_c_q     <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            status_q    <= '0;
        end else begin
            if (accept) begin
                rd_q        <= issue_rd;
                rn_q        <= issue_rn;
                rm_q        <= issue_rm;
                fs_q        <= issue_fs;
                c_q         <= issue_c;
                use_imm_q   <= issue_use_imm;
                imm_q       <= issue_imm;
                set_flags_q <= issue_set_flags;
            end
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_fs_q <= alu_fs_d;
            alu_c_q  <= alu_c_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            status_q <= status_d;
        end
    end

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_fs = alu_fs_q;
    assign alu_c  = alu_c_q;
    assign status = status_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with an adder stub standing in for the ALU.
module tb_alu_issue_unit;

    localparam int DW = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic          issue_ready;
    logic [4:0]    issue_rd, issue_rn, issue_rm, issue_fs;
    logic          issue_c, issue_use_imm, issue_set_flags;
    logic [DW-1:0] issue_imm;
    logic [DW-1:0] alu_a, alu_b, alu_f;
    logic [4:0]    alu_fs;
    logic          alu_c;
    logic [3:0]    alu_status;
    logic          done;
    logic [DW-1:0] result;
    logic [3:0]    status;
    logic [4:0]    dbg_addr;
    logic [DW-1:0] dbg_data;

    int tests = 0;
    int fails = 0;

    // Observations from the last run_op call.
    int            done_k;
    int            done_n;
    logic [DW-1:0] res_seen;
    logic [DW-1:0] ex_a, ex_b;
    logic [4:0]    ex_fs;
    logic          ex_c;
    logic          ready_wb, ready_after;
    logic [DW-1:0] a_in_wb;

    always #5 clock = ~clock;

    // ALU stub: f = a + b + c with {V,C,N,Z}.
    logic [DW:0] sum_ext;
    always_comb begin
        sum_ext    = {1'b0, alu_a} + {1'b0, alu_b} + {{DW{1'b0}}, alu_c};
        alu_f      = sum_ext[DW-1:0];
        alu_status = {(alu_a[DW-1] == alu_b[DW-1]) && (sum_ext[DW-1] != alu_a[DW-1]),
                      sum_ext[DW], sum_ext[DW-1], (sum_ext[DW-1:0] == '0)};
    end

    alu_issue_unit #(
        .DATA_W (DW),
        .REG_N  (32)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_rd        (issue_rd),
        .issue_rn        (issue_rn),
        .issue_rm        (issue_rm),
        .issue_fs        (issue_fs),
        .issue_c         (issue_c),
        .issue_use_imm   (issue_use_imm),
        .issue_imm       (issue_imm),
        .issue_set_flags (issue_set_flags),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_fs          (alu_fs),
        .alu_c           (alu_c),
        .alu_f           (alu_f),
        .alu_status      (alu_status),
        .done            (done),
        .result          (result),
        .status          (status),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data)
    );

    // Drive one request from IDLE and record what happens over the next six edges.
    task automatic run_op(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                          input logic [4:0] fs, input logic c, input logic use_imm,
                          input logic [DW-1:0] imm, input logic set_flags);
        @(negedge clock);
        issue_rd = rd; issue_rn = rn; issue_rm = rm; issue_fs = fs;
        issue_c = c; issue_use_imm = use_imm; issue_imm = imm;
        issue_set_flags = set_flags; issue_valid = 1'b1;
        @(posedge clock);
        #1 issue_valid = 1'b0;
        done_k = -1; done_n = 0; res_seen = '0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) begin
                ex_a = alu_a; ex_b = alu_b; ex_fs = alu_fs; ex_c = alu_c;
            end
            if (k == 2) begin
                ready_wb = issue_ready; a_in_wb = alu_a;
            end
            if (k == 3) ready_after = issue_ready;
            if (done) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k; res_seen = result;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        issue_valid = 1'b0; issue_rd = '0; issue_rn = '0; issue_rm = '0; issue_fs = '0;
        issue_c = 1'b0; issue_use_imm = 1'b0; issue_imm = '0; issue_set_flags = 1'b0;
        dbg_addr = '0;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            tests++;
            if (dbg_data !== '0) begin
                fails++;
                $display("FAIL reset_dbg[%0d] got %0h want 0", i, dbg_data);
            end
        end
        tests++;
        if (status !== 4'b0000) begin
            fails++; $display("FAIL reset_status got %b want 0000", status);
        end
        tests++;
        if (issue_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready got %b want 1", issue_ready);
        end
        tests++;
        if (done !== 1'b0 || result !== '0 || alu_a !== '0 || alu_b !== '0) begin
            fails++;
            $display("FAIL reset_outputs done=%b result=%0h alu_a=%0h alu_b=%0h want all 0",
                     done, result, alu_a, alu_b);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_imm_write();
        run_op(5'd1, 5'd31, 5'd0, 5'd7, 1'b0, 1'b1, 64'd205, 1'b0);
        tests++;
        if (done_k !== 2 || done_n !== 1) begin
            fails++; $display("FAIL imm1_done_timing got k=%0d n=%0d want k=2 n=1", done_k, done_n);
        end
        tests++;
        if (res_seen !== 64'd205) begin
            fails++; $display("FAIL imm1_result got %0d want 205", res_seen);
        end
        tests++;
        if (ex_a !== 64'd0 || ex_b !== 64'd205 || ex_fs !== 5'd7 || ex_c !== 1'b0) begin
            fails++;
            $display("FAIL imm1_alu_ports got a=%0d b=%0d fs=%0d c=%b want 0 205 7 0",
                     ex_a, ex_b, ex_fs, ex_c);
        end
        tests++;
        if (ready_wb !== 1'b0 || ready_after !== 1'b1 || a_in_wb !== '0) begin
            fails++;
            $display("FAIL imm1_ready got wb=%b after=%b alu_a_wb=%0h want 0 1 0",
                     ready_wb, ready_after, a_in_wb);
        end
        run_op(5'd2, 5'd31, 5'd0, 5'd0, 1'b0, 1'b1, 64'd512, 1'b0);
        dbg_addr = 5'd2;
        #1;
        tests++;
        if (dbg_data !== 64'd512) begin
            fails++; $display("FAIL imm2_r2 got %0d want 512", dbg_data);
        end
        dbg_addr = 5'd1;
        #1;
        tests++;
        if (dbg_data !== 64'd205) begin
            fails++; $display("FAIL imm2_r1 got %0d want 205", dbg_data);
        end
    endtask

    task automatic test_back_to_back();
        run_op(5'd3, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 64'd0, 1'b1);
        tests++;
        if (res_seen !== 64'd717 || status !== 4'b0000) begin
            fails++; $display("FAIL reg_add got res=%0d status=%b want 717 0000", res_seen, status);
        end
        run_op(5'd4, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1, {DW{1'b1}}, 1'b1);
        tests++;
        if (res_seen !== 64'd717) begin
            fails++; $display("FAIL carry_add_result got %0d want 717", res_seen);
        end
        tests++;
        if (status !== 4'b0100) begin
            fails++; $display("FAIL carry_add_status got %b want 0100", status);
        end
        dbg_addr = 5'd4;
        #1;
        tests++;
        if (dbg_data !== 64'd717) begin
            fails++; $display("FAIL carry_add_r4 got %0d want 717", dbg_data);
        end
    endtask

    task automatic test_zero_reg();
        run_op(5'd31, 5'd31, 5'd0, 5'd0, 1'b0, 1'b1, 64'd5, 1'b0);
        tests++;
        if (done_n !== 1 || res_seen !== 64'd5) begin
            fails++; $display("FAIL zero_reg_done got n=%0d res=%0d want 1 5", done_n, res_seen);
        end
        dbg_addr = 5'd31;
        #1;
        tests++;
        if (dbg_data !== '0) begin
            fails++; $display("FAIL zero_reg_read got %0d want 0", dbg_data);
        end
        tests++;
        if (status !== 4'b0100) begin
            fails++; $display("FAIL zero_reg_status got %b want 0100", status);
        end
    endtask

    task automatic test_held_valid();
        int acc_n;
        int acc_first;
        int acc_second;
        acc_n = 0; acc_first = -1; acc_second = -1;
        @(negedge clock);
        issue_rd = 5'd6; issue_rn = 5'd31; issue_rm = 5'd0; issue_fs = 5'd0;
        issue_c = 1'b0; issue_use_imm = 1'b1; issue_imm = 64'd1; issue_set_flags = 1'b0;
        issue_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (issue_ready) begin
                acc_n++;
                if (acc_first < 0) acc_first = i;
                else if (acc_second < 0) acc_second = i;
            end
            @(posedge clock);
            @(negedge clock);
        end
        issue_valid = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        tests++;
        if (acc_n !== 2) begin
            fails++; $display("FAIL held_valid_count got %0d want 2", acc_n);
        end
        tests++;
        if (acc_second - acc_first !== 4) begin
            fails++;
            $display("FAIL held_valid_spacing got %0d want 4", acc_second - acc_first);
        end
        dbg_addr = 5'd6;
        #1;
        tests++;
        if (dbg_data !== 64'd1) begin
            fails++; $display("FAIL held_valid_r6 got %0d want 1", dbg_data);
        end
    endtask

    task automatic test_reset_abort();
        int done_seen;
        done_seen = 0;
        @(negedge clock);
        issue_rd = 5'd5; issue_rn = 5'd31; issue_rm = 5'd0; issue_fs = 5'd0;
        issue_c = 1'b0; issue_use_imm = 1'b1; issue_imm = 64'd9; issue_set_flags = 1'b1;
        issue_valid = 1'b1;
        @(posedge clock);
        #1 issue_valid = 1'b0;
        @(posedge clock);
        #1;
        tests++;
        if (alu_b !== 64'd9) begin
            fails++; $display("FAIL abort_in_exec got alu_b=%0d want 9", alu_b);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (issue_ready !== 1'b1 || done !== 1'b0 || alu_b !== '0 || status !== 4'b0000) begin
            fails++;
            $display("FAIL abort_during_reset ready=%b done=%b alu_b=%0d status=%b want 1 0 0 0000",
                     issue_ready, done, alu_b, status);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            if (done) done_seen++;
        end
        tests++;
        if (done_seen !== 0) begin
            fails++; $display("FAIL abort_no_done got %0d pulses want 0", done_seen);
        end
        dbg_addr = 5'd5;
        #1;
        tests++;
        if (dbg_data !== '0 || issue_ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_r5 got r5=%0d ready=%b want 0 1", dbg_data, issue_ready);
        end
    endtask

    initial begin
        test_reset();
        test_imm_write();
        test_back_to_back();
        test_zero_reg();
        test_held_valid();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout reached at %0t want finish before 100000", $time);
        $fatal(1, "timeout");
    end

endmodule
